multicycle_ctrl_fsm: RTL and testbench

Multi-cycle sequencer for the RV64 datapath. It splits each instruction into FETCH/DECODE/EXEC/MEM/WB steps so that one ALU and one unified, wait-stated memory are reused across cycles. It drives all datapath mux selects and write enables, resolves branches from the ALU zero/less flags, and traps on an illegal opcode or a memory timeout. It replaces the single-cycle control unit when the core moves to a unified memory with a ready handshake.

---
 rtl/multicycle_ctrl_pkg.sv | 70 +++++++
 rtl/br_cond_eval.sv | 24 ++
 rtl/multicycle_ctrl_fsm.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: shared encodings for the multi-cycle RV64 sequencer.
// Holds the state encoding, opcode constants, ALUOp codes and operand-select codes.
// It also holds the funct3/funct7 to ALUOp decode used in EXEC.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERROR  = 3'd7
    } state_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } srca_e;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_FOUR = 2'b01,
        SRCB_IMM  = 2'b10
    } srcb_e;

    typedef struct packed {
        logic    legal;
        alu_op_e op;
    } alu_dec_t;

    // funct3 -> ALUOp; sub_en is only set for R-type with funct7[5] = 1.
    function automatic alu_dec_t alu_decode(input logic [2:0] funct3, input logic sub_en);
        alu_dec_t d;
        d.legal = 1'b1;
        d.op    = ALU_ADD;
        case (funct3)
            3'b000:  d.op = sub_en ? ALU_SUB : ALU_ADD;
            3'b111:  d.op = ALU_AND;
            3'b110:  d.op = ALU_OR;
            3'b100:  d.op = ALU_XOR;
            3'b010:  d.op = ALU_SLT;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    // Opcodes this sequencer knows how to step through.
    function automatic logic opcode_known(input logic [6:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_IALU) || (opcode == OP_LOAD) ||
               (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/br_cond_eval.sv
// br_cond_eval: branch resolution from funct3 and the ALU zero/less flags.
// Purely combinational; flags funct3 codes the core does not implement.
module br_cond_eval (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       less,
    output logic       taken,
    output logic       illegal
);

    // beq/bne use zero, blt/bge use signed less; anything else is illegal.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = less;
            3'b101:  taken = !less;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64 datapath
// with one ALU and one wait-stated unified memory. Outputs are a combinational
// decode of the registered state plus inputs. FETCH and MEM waits are bounded
// by MEM_TIMEOUT (0 = unbounded).
// Optional macro CTRL_PERF_CNT_EN adds 64-bit cycle_cnt and instret_cnt outputs.
module multicycle_ctrl_fsm
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic        zero,
    input  logic        less,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        OldPCWrite,
    output logic        IRWrite,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  ALUOp,
    output logic        PCSource,
    output logic [2:0]  state,
    output logic        err
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
`endif
);

    // Last wait cycle still allowed without mem_ready; only meaningful when MEM_TIMEOUT > 0.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_taken, br_illegal;
    alu_dec_t         alu_dec;
    logic             is_rtype, is_store;
    logic             mem_wait, timeout_hit;
    logic             unused_funct7;

    br_cond_eval u_br_cond_eval (
        .funct3  (funct3),
        .zero    (zero),
        .less    (less),
        .taken   (br_taken),
        .illegal (br_illegal)
    );

    assign is_rtype      = (opcode == OP_RTYPE);
    assign is_store      = (opcode == OP_STORE);
    assign alu_dec       = alu_decode(funct3, is_rtype & funct7[5]);
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // A mem_ready in the same cycle always wins over the timeout.
    assign mem_wait    = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
    assign timeout_hit = (MEM_TIMEOUT != 0) && mem_wait && (cnt_q == TO_LAST);

    // Wait counter runs only while the same access keeps waiting.
    assign cnt_d = (mem_wait && (state_d == state_q)) ? cnt_q + 1'b1 : '0;

    // Next state and every datapath control; anything not driven in a state is 0.
    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        OldPCWrite = 1'b0;
        IRWrite    = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        MemToReg   = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ALUOp      = ALU_AND;
        PCSource   = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                // PC + 4 is computed while the instruction is read.
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                ALUOp   = ALU_ADD;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    OldPCWrite = 1'b1;
                    PCWrite    = 1'b1;
                    state_d    = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_ERROR;
                end
            end
            S_DECODE: begin
                // Branch target OldPC + imm lands in ALUOut for a later taken branch.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALU_ADD;
                state_d = opcode_known(opcode) ? S_EXEC : S_ERROR;
            end
            S_EXEC: begin
                case (opcode)
                    OP_RTYPE, OP_IALU: begin
                        // Unsupported funct3 leaves all controls at 0 on the way to ERROR.
                        if (alu_dec.legal) begin
                            ALUSrcA = SRCA_RS1;
                            ALUSrcB = is_rtype ? SRCB_RS2 : SRCB_IMM;
                            ALUOp   = alu_dec.op;
                            state_d = S_WB;
                        end else begin
                            state_d = S_ERROR;
                        end
                    end
                    OP_LOAD, OP_STORE: begin
                        ALUSrcA = SRCA_RS1;
                        ALUSrcB = SRCB_IMM;
                        ALUOp   = ALU_ADD;
                        state_d = S_MEM;
                    end
                    OP_BRANCH: begin
                        ALUSrcA = SRCA_RS1;
                        ALUSrcB = SRCB_RS2;
                        ALUOp   = ALU_SUB;
                        if (br_illegal) begin
                            state_d = S_ERROR;
                        end else begin
                            PCWrite  = br_taken;
                            PCSource = br_taken;
                            state_d  = S_FETCH;
                        end
                    end
                    default: state_d = S_ERROR;
                endcase
            end
            S_MEM: begin
                IorD     = 1'b1;
                MemRead  = !is_store;
                MemWrite = is_store;
                if (mem_ready) begin
                    state_d = is_store ? S_FETCH : S_WB;
                end else if (timeout_hit) begin
                    state_d = S_ERROR;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                MemToReg = (opcode == OP_LOAD);
                state_d  = S_FETCH;
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase
    end

    // State register and wait counter; reset forces IDLE immediately.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = state_q;
    assign err   = (state_q == S_ERROR);

`ifdef CTRL_PERF_CNT_EN
    logic [63:0] cycle_q, instret_q;
    logic        retire;

    // An instruction retires when it hands control back to FETCH.
    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_WB) || (state_q == S_MEM) || (state_q == S_EXEC));

    // Free-running performance counters, wrapping modulo 2^64.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if ((state_q != S_IDLE) && (state_q != S_ERROR)) cycle_q <= cycle_q + 64'd1;
            if (retire) instret_q <= instret_q + 64'd1;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: builds the expected per-cycle control trace of each
// instruction from its opcode, funct fields, flags and memory wait lengths,
// then drives the sequencer and compares every cycle against that trace.
module tb_multicycle_ctrl_fsm;

    localparam int MEM_TIMEOUT = 16;

    localparam logic [6:0] R_OP = 7'b0110011;
    localparam logic [6:0] I_OP = 7'b0010011;
    localparam logic [6:0] LD_OP = 7'b0000011;
    localparam logic [6:0] ST_OP = 7'b0100011;
    localparam logic [6:0] BR_OP = 7'b1100011;

    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001;
    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_XOR = 4'b0011;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_SLT = 4'b0111;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic       zero = 1'b0, less = 1'b0, mem_ready = 1'b0;
    logic       PCWrite, OldPCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemToReg;
    logic [1:0] ALUSrcA, ALUSrcB;
    logic [3:0] ALUOp;
    logic       PCSource;
    logic [2:0] state;
    logic       err;
`ifdef CTRL_PERF_CNT_EN
    logic [63:0] cycle_cnt, instret_cnt;
    longint unsigned exp_cyc = 0, exp_ret = 0;
`endif

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(5)) dut (
        .CLK(CLK), .RST(RST), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .less(less), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .OldPCWrite(OldPCWrite), .IRWrite(IRWrite), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .state(state), .err(err)
`ifdef CTRL_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic       rdy;
        logic       z;
        logic       l;
        logic       retire;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
    } stim_t;

    stim_t       stim_q[$];
    logic [20:0] exp_q[$];
    logic [20:0] obs_vec;
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic [6:0] cur_f7;
    logic       cur_z, cur_l;

    // {enables, ALUSrcA, ALUSrcB, ALUOp, PCSource, state, err};
    // enables = {PCWrite, OldPCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemToReg}
    assign obs_vec = {PCWrite, OldPCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemToReg,
                      ALUSrcA, ALUSrcB, ALUOp, PCSource, state, err};

    function automatic logic [20:0] vec(input logic [2:0] st, input logic [7:0] en,
                                        input logic [1:0] sa, input logic [1:0] sb,
                                        input logic [3:0] op, input logic pcs);
        return {en, sa, sb, op, pcs, st, (st == 3'd7)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Returns {legal, ALUOp} for an R/I instruction.
    function automatic logic [4:0] exp_alu(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return {1'b1, sub ? A_SUB : A_ADD};
            3'b111:  return {1'b1, A_AND};
            3'b110:  return {1'b1, A_OR};
            3'b100:  return {1'b1, A_XOR};
            3'b010:  return {1'b1, A_SLT};
            default: return 5'b0;
        endcase
    endfunction

    // Returns {legal, taken} for a branch.
    function automatic logic [1:0] exp_br(input logic [2:0] f3, input logic z, input logic l);
        case (f3)
            3'b000:  return {1'b1, z};
            3'b001:  return {1'b1, !z};
            3'b100:  return {1'b1, l};
            3'b101:  return {1'b1, !l};
            default: return 2'b00;
        endcase
    endfunction

    task automatic push(input logic rdy, input logic ret, input logic [20:0] e);
        stim_t s;
        s.rdy = rdy; s.z = cur_z; s.l = cur_l; s.retire = ret;
        s.op = cur_op; s.f3 = cur_f3; s.f7 = cur_f7;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected trace of one instruction; errd = it ends in ERROR.
    task automatic gen_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic z, input logic l, input int fw, input int mw,
                             output bit errd);
        logic [4:0]  a;
        logic [1:0]  b;
        logic [20:0] mv;
        logic        is_r;
        errd = 1'b0;
        cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_z = z; cur_l = l;
        for (int i = 0; i < fw && i < MEM_TIMEOUT; i++)
            push(1'b0, 1'b0, vec(3'd1, 8'h08, 2'b00, 2'b01, A_ADD, 1'b0));
        if (fw >= MEM_TIMEOUT) begin
            errd = 1'b1;
            return;
        end
        push(1'b1, 1'b0, vec(3'd1, 8'hE8, 2'b00, 2'b01, A_ADD, 1'b0));
        push(rnd_bit(), 1'b0, vec(3'd2, 8'h00, 2'b01, 2'b10, A_ADD, 1'b0));
        case (op)
            R_OP, I_OP: begin
                is_r = (op == R_OP);
                a = exp_alu(f3, is_r && f7[5]);
                if (!a[4]) begin
                    push(rnd_bit(), 1'b0, vec(3'd3, 8'h00, 2'b00, 2'b00, 4'b0000, 1'b0));
                    errd = 1'b1;
                end else begin
                    push(rnd_bit(), 1'b0, vec(3'd3, 8'h00, 2'b10, is_r ? 2'b00 : 2'b10, a[3:0], 1'b0));
                    push(rnd_bit(), 1'b1, vec(3'd5, 8'h02, 2'b00, 2'b00, 4'b0000, 1'b0));
                end
            end
            LD_OP, ST_OP: begin
                push(rnd_bit(), 1'b0, vec(3'd3, 8'h00, 2'b10, 2'b10, A_ADD, 1'b0));
                mv = vec(3'd4, (op == ST_OP) ? 8'h14 : 8'h18, 2'b00, 2'b00, 4'b0000, 1'b0);
                for (int i = 0; i < mw && i < MEM_TIMEOUT; i++) push(1'b0, 1'b0, mv);
                if (mw >= MEM_TIMEOUT) begin
                    errd = 1'b1;
                end else begin
                    push(1'b1, op == ST_OP, mv);
                    if (op == LD_OP)
                        push(rnd_bit(), 1'b1, vec(3'd5, 8'h03, 2'b00, 2'b00, 4'b0000, 1'b0));
                end
            end
            BR_OP: begin
                b = exp_br(f3, z, l);
                push(rnd_bit(), b[1], vec(3'd3, (b[1] && b[0]) ? 8'h80 : 8'h00, 2'b10, 2'b00,
                                         A_SUB, b[1] && b[0]));
                if (!b[1]) errd = 1'b1;
            end
            default: errd = 1'b1;
        endcase
    endtask

    // ---------------- driver ----------------
    task automatic run_plan();
        stim_t       s;
        logic [20:0] e;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            @(negedge CLK);
            mem_ready = s.rdy; zero = s.z; less = s.l;
            opcode = s.op; funct3 = s.f3; funct7 = s.f7;
            #2;
            check("ctrl", {43'd0, obs_vec}, {43'd0, e});
`ifdef CTRL_PERF_CNT_EN
            check("cycle_cnt", cycle_cnt, exp_cyc);
            check("instret_cnt", instret_cnt, exp_ret);
            if (e[3:1] != 3'd0 && e[3:1] != 3'd7) exp_cyc++;
            if (s.retire) exp_ret++;
`endif
        end
    endtask

    // Holds reset, checks the reset outputs, releases just after a rising edge.
    task automatic do_reset();
        RST = 1'b0;
        mem_ready = rnd_bit();
        #1;
        check("rst_outputs", {43'd0, obs_vec}, {43'd0, vec(3'd0, 8'h00, 2'b00, 2'b00, 4'b0000, 1'b0)});
`ifdef CTRL_PERF_CNT_EN
        check("rst_cycle_cnt", cycle_cnt, 64'd0);
        check("rst_instret_cnt", instret_cnt, 64'd0);
        exp_cyc = 0;
        exp_ret = 0;
`endif
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        push(rnd_bit(), 1'b0, vec(3'd0, 8'h00, 2'b00, 2'b00, 4'b0000, 1'b0));
    endtask

    task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic z, input logic l, input int fw, input int mw);
        bit e;
        gen_instr(op, f3, f7, z, l, fw, mw, e);
        if (e) repeat (3) push(rnd_bit(), 1'b0, vec(3'd7, 8'h00, 2'b00, 2'b00, 4'b0000, 1'b0));
        run_plan();
        if (e) do_reset();
    endtask

    // ---------------- stimulus ----------------
    logic [2:0] alu_f3[5] = '{3'b000, 3'b111, 3'b110, 3'b100, 3'b010};
    logic [2:0] br_f3[4]  = '{3'b000, 3'b001, 3'b100, 3'b101};

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int         k, fw, mw;

        cur_op = '0; cur_f3 = '0; cur_f7 = '0; cur_z = 1'b0; cur_l = 1'b0;
        do_reset();

        // Directed cases
        do_instr(R_OP, 3'b000, 7'h00, 1'b0, 1'b0, 0, 0);    // add x3,x1,x2
        do_instr(LD_OP, 3'b011, 7'h00, 1'b0, 1'b0, 0, 3);   // ld, 3 wait cycles
        do_instr(BR_OP, 3'b000, 7'h00, 1'b1, 1'b0, 0, 0);   // beq taken
        do_instr(BR_OP, 3'b000, 7'h00, 1'b0, 1'b0, 0, 0);   // beq not taken
        do_instr(BR_OP, 3'b101, 7'h00, 1'b0, 1'b1, 0, 0);   // bge, less=1
        do_instr(R_OP, 3'b000, 7'h20, 1'b0, 1'b0, 1, 0);    // sub
        do_instr(I_OP, 3'b000, 7'h20, 1'b0, 1'b0, 0, 0);    // addi ignores funct7
        do_instr(ST_OP, 3'b011, 7'h00, 1'b0, 1'b0, 2, 15);  // store, ready on last allowed cycle
        do_instr(R_OP, 3'b000, 7'h00, 1'b0, 1'b0, 15, 0);   // fetch ready on 16th cycle
        do_instr(7'b1111111, 3'b000, 7'h00, 1'b0, 1'b0, 0, 0); // illegal opcode
        do_instr(R_OP, 3'b000, 7'h00, 1'b0, 1'b0, 16, 0);   // fetch timeout
        do_instr(LD_OP, 3'b011, 7'h00, 1'b0, 1'b0, 0, 16);  // memory timeout
        do_instr(BR_OP, 3'b010, 7'h00, 1'b1, 1'b1, 0, 0);   // illegal branch funct3
        do_instr(R_OP, 3'b001, 7'h00, 1'b0, 1'b0, 0, 0);    // unsupported R funct3

        // Reset in the middle of a waiting store
        cur_op = ST_OP; cur_f3 = 3'b011; cur_f7 = 7'h00; cur_z = 1'b0; cur_l = 1'b0;
        push(1'b1, 1'b0, vec(3'd1, 8'hE8, 2'b00, 2'b01, A_ADD, 1'b0));
        push(1'b1, 1'b0, vec(3'd2, 8'h00, 2'b01, 2'b10, A_ADD, 1'b0));
        push(1'b0, 1'b0, vec(3'd3, 8'h00, 2'b10, 2'b10, A_ADD, 1'b0));
        push(1'b0, 1'b0, vec(3'd4, 8'h14, 2'b00, 2'b00, 4'b0000, 1'b0));
        push(1'b0, 1'b0, vec(3'd4, 8'h14, 2'b00, 2'b00, 4'b0000, 1'b0));
        run_plan();
        @(posedge CLK);
        #3 RST = 1'b0;
        #1;
        check("rst_mid_mem_memwrite", {63'd0, MemWrite}, 64'd0);
        check("rst_mid_mem_state", {61'd0, state}, 64'd0);
        do_reset();

        // Randomized instruction stream
        for (int n = 0; n < 80; n++) begin
            k  = $urandom_range(0, 9);
            f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            f3 = alu_f3[$urandom_range(0, 4)];
            case (k)
                0, 1, 2: op = R_OP;
                3, 4:    begin op = I_OP; f7 = 7'($urandom_range(0, 127)); end
                5:       op = LD_OP;
                6:       op = ST_OP;
                7, 8:    begin op = BR_OP; f3 = br_f3[$urandom_range(0, 3)]; end
                default: op = 7'($urandom_range(0, 127));
            endcase
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
            fw = ($urandom_range(0, 19) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
            mw = ($urandom_range(0, 19) == 0) ? $urandom_range(14, 17) : $urandom_range(0, 3);
            do_instr(op, f3, f7, rnd_bit(), rnd_bit(), fw, mw);
        end
        run_plan();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
